// File: rtl/rtlola_trace_player.sv
// Trace player: stores up to DEPTH timed input events and replays them into a
// monitor as registered (value, new_input) pulses, with loop, abort and enable freeze.
module rtlola_trace_player #(
  parameter int unsigned NUM_IN  = 3,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned DELTA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [DELTA_W-1:0]       load_delta,
  input  logic [NUM_IN-1:0]        load_mask,
  input  logic [NUM_IN*DATA_W-1:0] load_data,
  input  logic                     start,
  input  logic                     loop_en,
  input  logic                     abort,
  input  logic                     clear,
  output logic [NUM_IN*DATA_W-1:0] input_data,
  output logic [NUM_IN-1:0]        new_input,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              ev_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned DAT_W = NUM_IN * DATA_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_FIRE = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DELTA_W-1:0] gap_q, gap_d;
  logic [15:0]        ev_count_q, ev_count_d;
  logic [NUM_IN-1:0]  new_input_q;
  logic [DAT_W-1:0]   input_data_q;
  logic               busy_q;
  logic               done_q;

  logic [DELTA_W-1:0] mem_delta_q [DEPTH];
  logic [NUM_IN-1:0]  mem_mask_q  [DEPTH];
  logic [DAT_W-1:0]   mem_data_q  [DEPTH];

  logic               mem_we_c;
  logic               fire_c;
  logic               last_c;
  logic               start_ok_c;
  logic [PTR_W-1:0]   nxt_ptr_c;
  logic [DAT_W-1:0]   fire_data_c;

  assign load_ready = (state_q == S_IDLE) && (count_q < CNT_W'(DEPTH)) && !start;
  assign start_ok_c = start && en;
  assign last_c     = (CNT_W'(rd_ptr_q) == (count_q - CNT_W'(1)));
  assign nxt_ptr_c  = rd_ptr_q + PTR_W'(1);

  // Trace RAM: no reset, entries appended at the current fill level.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_delta_q[count_q[PTR_W-1:0]] <= load_delta;
      mem_mask_q[count_q[PTR_W-1:0]]  <= load_mask;
      mem_data_q[count_q[PTR_W-1:0]]  <= load_data;
    end
  end

  // Channel values of the current entry, zeroed where the mask bit is clear.
  always_comb begin
    fire_data_c = '0;
    for (int i = 0; i < int'(NUM_IN); i++) begin
      if (mem_mask_q[rd_ptr_q][i]) begin
        fire_data_c[i*DATA_W +: DATA_W] = mem_data_q[rd_ptr_q][i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      gap_q        <= '0;
      ev_count_q   <= '0;
      new_input_q  <= '0;
      input_data_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      gap_q        <= gap_d;
      ev_count_q   <= ev_count_d;
      // Outputs are loaded on entry to a state so pulses line up with FIRE.
      new_input_q  <= fire_c ? mem_mask_q[rd_ptr_q] : '0;
      input_data_q <= fire_c ? fire_data_c : '0;
      busy_q       <= (state_d == S_WAIT) || (state_d == S_FIRE);
      done_q       <= (state_d == S_DONE);
    end
  end

  // Next state; abort beats clear beats start beats load.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    gap_d      = gap_q;
    ev_count_d = ev_count_q;
    mem_we_c   = 1'b0;
    fire_c     = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (clear) begin
            count_d = '0;
            state_d = S_IDLE;
          end else if (start_ok_c) begin
            ev_count_d = '0;
            rd_ptr_d   = '0;
            if (count_q == '0) begin
              state_d = S_DONE;
            end else begin
              gap_d   = mem_delta_q[0];
              state_d = S_WAIT;
            end
          end else if (load_valid && load_ready) begin
            mem_we_c = 1'b1;
            count_d  = count_q + CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (en) begin
            if (gap_q == '0) begin
              fire_c  = 1'b1;
              state_d = S_FIRE;
              if ((mem_mask_q[rd_ptr_q] != '0) && (ev_count_q != 16'hFFFF)) begin
                ev_count_d = ev_count_q + 16'd1;
              end
            end else begin
              gap_d = gap_q - DELTA_W'(1);
            end
          end
        end
        S_FIRE: begin
          if (last_c) begin
            if (loop_en) begin
              rd_ptr_d = '0;
              gap_d    = mem_delta_q[0];
              state_d  = S_WAIT;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            rd_ptr_d = nxt_ptr_c;
            gap_d    = mem_delta_q[nxt_ptr_c];
            state_d  = S_WAIT;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign input_data = input_data_q;
  assign new_input  = new_input_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign ev_count   = ev_count_q;

endmodule

// File: tb/tb_rtlola_trace_player.sv
// Directed bench for rtlola_trace_player: expected pulses are scheduled from a
// small trace model and compared cycle-by-cycle against the DUT outputs.
module tb_rtlola_trace_player;

  localparam int unsigned NUM_IN = 3;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned DAT_W  = NUM_IN * DATA_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b1;
  logic              load_valid = 1'b0;
  logic              load_ready;
  logic [31:0]       load_delta = '0;
  logic [2:0]        load_mask = '0;
  logic [DAT_W-1:0]  load_data = '0;
  logic              start = 1'b0;
  logic              loop_en = 1'b0;
  logic              abort = 1'b0;
  logic              clear = 1'b0;
  logic [DAT_W-1:0]  input_data;
  logic [2:0]        new_input;
  logic              busy;
  logic              done;
  logic [15:0]       ev_count;

  rtlola_trace_player dut (
    .clk(clk), .rst(rst), .en(en),
    .load_valid(load_valid), .load_ready(load_ready), .load_delta(load_delta),
    .load_mask(load_mask), .load_data(load_data),
    .start(start), .loop_en(loop_en), .abort(abort), .clear(clear),
    .input_data(input_data), .new_input(new_input),
    .busy(busy), .done(done), .ev_count(ev_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned      cyc;
    logic [2:0]       mask;
    logic [DAT_W-1:0] data;
  } exp_t;

  exp_t             exp_q[$];
  int unsigned      md[$];
  logic [2:0]       mm[$];
  logic [DAT_W-1:0] mv[$];
  int               errors = 0;
  int               checks = 0;
  logic             mon_en = 1'b0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [DAT_W-1:0] masked(input logic [2:0] m, input logic [DAT_W-1:0] v);
    logic [DAT_W-1:0] r;
    r = '0;
    for (int i = 0; i < 3; i++) if (m[i]) r[i*DATA_W +: DATA_W] = v[i*DATA_W +: DATA_W];
    return r;
  endfunction

  function automatic logic [DAT_W-1:0] splat(input logic [63:0] a, input logic [63:0] b,
                                              input logic [63:0] c);
    return {c, b, a};
  endfunction

  // Scoreboard: every cycle either matches the head pulse or must be silent.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        chk("pulse_mask", 256'(new_input), 256'(exp_q[0].mask));
        chk("pulse_data", 256'(input_data), 256'(exp_q[0].data));
        void'(exp_q.pop_front());
      end else begin
        chk("idle_outputs", 256'({new_input, input_data}), 256'(0));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int unsigned t);
    while (cyc < t) tick(1);
  endtask

  task automatic load_entry(input int unsigned d, input logic [2:0] m,
                            input logic [DAT_W-1:0] v, output logic acc);
    load_valid = 1'b1;
    load_delta = d;
    load_mask  = m;
    load_data  = v;
    @(negedge clk);
    acc = load_ready;
    tick(1);
    load_valid = 1'b0;
    if (acc) begin
      md.push_back(d);
      mm.push_back(m);
      mv.push_back(v);
    end
  endtask

  task automatic do_start(output int unsigned t);
    start = 1'b1;
    t = cyc;
    tick(1);
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    md.delete();
    mm.delete();
    mv.delete();
  endtask

  // Fire k lands delta_k+2 cycles after fire k-1 (first: start cycle + 2 + delta_0).
  task automatic push_schedule(input int unsigned t, input int n_fires, output int unsigned last);
    int unsigned cur;
    exp_t e;
    cur = t;
    for (int k = 0; k < n_fires; k++) begin
      int idx;
      idx = k % md.size();
      cur = cur + md[idx] + 2;
      if (mm[idx] != 3'b000) begin
        e.cyc  = cur;
        e.mask = mm[idx];
        e.data = masked(mm[idx], mv[idx]);
        exp_q.push_back(e);
      end
    end
    last = cur;
  endtask

  initial begin
    int unsigned t, t2, last;
    logic acc;
    exp_t e;

    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_new_input", 256'(new_input), 256'(0));
    chk("rst_input_data", 256'(input_data), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_ev_count", 256'(ev_count), 256'(0));
    chk("rst_load_ready", 256'(load_ready), 256'(1));
    mon_en = 1'b1;

    // Basic three-entry trace.
    load_entry(0, 3'b111, splat(64'd1, 64'd1, 64'd1), acc);
    load_entry(2, 3'b111, splat(64'd2, 64'd2, 64'd2), acc);
    load_entry(0, 3'b010, splat(64'd3, 64'd3, 64'd3), acc);
    do_start(t);
    push_schedule(t, 3, last);
    chk("t1_busy", 256'(busy), 256'(1));
    wait_until(t + 8);
    chk("t1_done_early", 256'(done), 256'(0));
    tick(1);
    chk("t1_done", 256'(done), 256'(1));
    chk("t1_busy_end", 256'(busy), 256'(0));
    chk("t1_ev_count", 256'(ev_count), 256'(3));
    chk("t1_all_pulses", 256'(exp_q.size()), 256'(0));
    do_clear();
    chk("t1_clear_done", 256'(done), 256'(0));

    // Zero-mask time step between two events.
    load_entry(0, 3'b001, splat(64'd10, 64'd11, 64'd12), acc);
    load_entry(5, 3'b000, splat(64'd99, 64'd99, 64'd99), acc);
    load_entry(1, 3'b100, splat(64'd30, 64'd31, 64'h8000_0000_0000_0001), acc);
    do_start(t);
    push_schedule(t, 3, last);
    wait_until(last + 1);
    chk("t2_done", 256'(done), 256'(1));
    chk("t2_ev_count", 256'(ev_count), 256'(2));
    chk("t2_all_pulses", 256'(exp_q.size()), 256'(0));
    do_clear();

    // Fill past DEPTH; the 17th offer must be refused.
    for (int i = 0; i < 17; i++) begin
      load_entry(0, 3'((i % 7) + 1), splat(64'(i), 64'(i + 100), 64'(i + 200)), acc);
      chk("t3_load_ready", 256'(acc), 256'(i < 16));
    end
    do_start(t);
    push_schedule(t, 16, last);
    wait_until(last + 1);
    chk("t3_done", 256'(done), 256'(1));
    chk("t3_ev_count", 256'(ev_count), 256'(16));
    chk("t3_all_pulses", 256'(exp_q.size()), 256'(0));

    // Asynchronous reset in the middle of the first FIRE cycle.
    mon_en = 1'b0;
    do_start(t);
    wait_until(t + 2);
    chk("t4_fire_mask", 256'(new_input), 256'(mm[0]));
    #2 rst = 1'b1;
    #1;
    chk("t4_rst_new_input", 256'(new_input), 256'(0));
    chk("t4_rst_input_data", 256'(input_data), 256'(0));
    chk("t4_rst_busy", 256'(busy), 256'(0));
    tick(1);
    rst = 1'b0;
    md.delete();
    mm.delete();
    mv.delete();
    mon_en = 1'b1;
    tick(1);
    chk("t4_load_ready", 256'(load_ready), 256'(1));
    chk("t4_ev_count", 256'(ev_count), 256'(0));
    do_start(t);
    chk("t4_empty_done", 256'(done), 256'(1));
    chk("t4_empty_busy", 256'(busy), 256'(0));
    do_clear();

    // Loop mode, then abort during WAIT and a fresh replay from entry 0.
    load_entry(1, 3'b111, splat(64'd7, 64'd8, 64'd9), acc);
    load_entry(1, 3'b101, splat(64'd4, 64'd5, 64'd6), acc);
    loop_en = 1'b1;
    do_start(t);
    push_schedule(t, 3, last);
    wait_until(t + 10);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("t5_abort_busy", 256'(busy), 256'(0));
    chk("t5_abort_done", 256'(done), 256'(0));
    chk("t5_abort_ev_count", 256'(ev_count), 256'(3));
    wait_until(t + 15);
    loop_en = 1'b0;
    do_start(t2);
    push_schedule(t2, 2, last);
    wait_until(last + 1);
    chk("t5_restart_done", 256'(done), 256'(1));
    chk("t5_restart_ev_count", 256'(ev_count), 256'(2));
    chk("t5_all_pulses", 256'(exp_q.size()), 256'(0));
    do_clear();

    // Enable freeze during WAIT delays the pulse; en low on FIRE does not.
    load_entry(3, 3'b111, splat(64'd5, 64'd5, 64'd5), acc);
    load_entry(0, 3'b011, splat(64'd6, 64'd6, 64'd6), acc);
    do_start(t);
    e.cyc = t + 9;  e.mask = 3'b111; e.data = splat(64'd5, 64'd5, 64'd5); exp_q.push_back(e);
    e.cyc = t + 11; e.mask = 3'b011; e.data = splat(64'd6, 64'd6, 64'd0); exp_q.push_back(e);
    wait_until(t + 2);
    en = 1'b0;
    tick(4);
    en = 1'b1;
    wait_until(t + 11);
    en = 1'b0;
    tick(1);
    en = 1'b1;
    chk("t6_done", 256'(done), 256'(1));
    chk("t6_ev_count", 256'(ev_count), 256'(2));
    tick(2);
    chk("t6_all_pulses", 256'(exp_q.size()), 256'(0));

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
